// File: rtl/fifo_ctrl_1r1w_sync_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_1r1w_sync_pkg
//   Shared definitions for the 1R1W synchronous-read FIFO controller.
//   - DefaultWidth / DefaultDepth : default parameter values for the top.
//   - xfer_t                      : per-cycle transfer events (push, pop,
//                                   read-during-write collision), gathered in
//                                   one struct so checkers can bind to it.
// Optional feature macro used by the top: FIFO_CTRL_BYPASS_EN.
// ---------------------------------------------------------------------------
package fifo_ctrl_1r1w_sync_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 16;

  typedef struct packed {
    logic push;       // producer beat accepted this cycle
    logic pop;        // consumer beat accepted this cycle
    logic collision;  // push targets the slot being read next cycle
  } xfer_t;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_ptr
//   Wrap-bit FIFO pointer: $clog2(depth_p) address bits plus one wrap bit.
//   The low bits roll over from depth_p-1 to 0 and the wrap bit toggles at
//   the same time; this falls out of plain binary addition because depth_p
//   is a power of two.
// Ports
//   clk_i       in   1          clock, rising edge
//   reset_ni    in   1          async active-low reset, pointer -> 0
//   inc_i       in   1          advance pointer this cycle
//   ptr_o       out  AW+1       current pointer (registered)
//   ptr_next_o  out  AW+1       pointer after this cycle (ptr_o + inc_i)
// ---------------------------------------------------------------------------
module fifo_ctrl_ptr #(
  parameter int unsigned depth_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     inc_i,
  output logic [$clog2(depth_p):0] ptr_o,
  output logic [$clog2(depth_p):0] ptr_next_o
);

  localparam int unsigned PtrW = $clog2(depth_p) + 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;

  assign ptr_d = ptr_q + PtrW'(inc_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign ptr_next_o = ptr_d;

endmodule

// File: rtl/fifo_ctrl_1r1w_sync.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_1r1w_sync
//   Ready/valid FIFO controller driving an external 1R1W RAM whose read data
//   returns one cycle after the read address. Owns the pointers, occupancy,
//   full/empty status and the read-during-write hazard.
//
// Handshake: a beat moves on an interface only in a cycle where both valid
//   and ready are high (push = valid_i & ready_o, pop = valid_o & ready_i).
//   valid is never withdrawn without a transfer and its data is held stable
//   while waiting; ready_o is a registered !full flag.
//
// Optional feature (compile-time macro FIFO_CTRL_BYPASS_EN):
//   defined   -> a collision captures data_i into a bypass register, which
//                feeds data_o the next cycle with no valid_o bubble.
//   undefined -> a collision costs one valid_o bubble while the RAM catches up.
//
// Ports
//   clk_i           in   1                  clock, rising edge
//   reset_ni        in   1                  async active-low reset
//   valid_i         in   1                  producer has data_i
//   data_i          in   width_p            push data
//   ready_o         out  1                  FIFO can accept
//   valid_o         out  1                  data_o holds the head entry
//   data_o          out  width_p            head data
//   ready_i         in   1                  consumer accepts
//   count_o         out  $clog2(depth_p+1)  stored entries
//   ram_wr_valid_o  out  1                  RAM write enable (= push)
//   ram_wr_addr_o   out  $clog2(depth_p)    RAM write address
//   ram_wr_data_o   out  width_p            RAM write data (= data_i)
//   ram_rd_addr_o   out  $clog2(depth_p)    RAM read address (next head)
//   ram_rd_data_i   in   width_p            RAM data for last cycle's address
// ---------------------------------------------------------------------------
module fifo_ctrl_1r1w_sync
  import fifo_ctrl_1r1w_sync_pkg::*;
#(
  parameter int unsigned width_p = DefaultWidth,
  parameter int unsigned depth_p = DefaultDepth   // power of two, >= 2
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic                         valid_i,
  input  logic [width_p-1:0]           data_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [width_p-1:0]           data_o,
  input  logic                         ready_i,
  output logic [$clog2(depth_p+1)-1:0] count_o,
  output logic                         ram_wr_valid_o,
  output logic [$clog2(depth_p)-1:0]   ram_wr_addr_o,
  output logic [width_p-1:0]           ram_wr_data_o,
  output logic [$clog2(depth_p)-1:0]   ram_rd_addr_o,
  input  logic [width_p-1:0]           ram_rd_data_i
);

  localparam int unsigned AddrW = $clog2(depth_p);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(depth_p + 1);

  xfer_t           xfer;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] wr_ptr_next;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] rd_ptr_next;
  logic [PtrW-1:0] occ;
  logic [PtrW-1:0] occ_next;

  logic ready_q;
  logic ready_d;
  logic valid_q;
  logic valid_d;

  // -------------------------------------------------------------------------
  // Transfer events
  // -------------------------------------------------------------------------
  always_comb begin
    xfer = '0;
    // Reset gates the push so nothing reaches the RAM while reset_ni is low,
    // even though ready_o already reads 1 then.
    xfer.push      = valid_i & ready_q & reset_ni;
    xfer.pop       = valid_q & ready_i;
    // The RAM read issued this cycle targets the slot being written: its
    // read-during-write result is undefined and must not reach data_o.
    // Full-pointer equality means the FIFO is empty after this cycle's pop.
    xfer.collision = xfer.push & (wr_ptr == rd_ptr_next);
  end

  // -------------------------------------------------------------------------
  // Pointers
  // -------------------------------------------------------------------------
  fifo_ctrl_ptr #(
    .depth_p    (depth_p)
  ) u_wr_ptr (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .inc_i      (xfer.push),
    .ptr_o      (wr_ptr),
    .ptr_next_o (wr_ptr_next)
  );

  fifo_ctrl_ptr #(
    .depth_p    (depth_p)
  ) u_rd_ptr (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .inc_i      (xfer.pop),
    .ptr_o      (rd_ptr),
    .ptr_next_o (rd_ptr_next)
  );

  // Occupancy is the modular pointer difference; the wrap bit makes full
  // (difference == depth_p) distinct from empty (difference == 0).
  assign occ      = wr_ptr - rd_ptr;
  assign occ_next = wr_ptr_next - rd_ptr_next;

  // -------------------------------------------------------------------------
  // Status flags
  // -------------------------------------------------------------------------
  always_comb begin
    ready_d = (occ_next != PtrW'(depth_p));
`ifdef FIFO_CTRL_BYPASS_EN
    // A colliding entry is served from the bypass register, so any stored
    // entry makes the head valid next cycle.
    valid_d = (occ_next != '0);
`else
    // After a collision the read address is held one more cycle so the RAM
    // returns the freshly written entry; valid_o bubbles meanwhile.
    valid_d = (occ_next != '0) & ~xfer.collision;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Head data
  // -------------------------------------------------------------------------
`ifdef FIFO_CTRL_BYPASS_EN
  logic [width_p-1:0] byp_q;
  logic [width_p-1:0] byp_d;
  logic               byp_sel_q;
  logic               byp_sel_d;

  always_comb begin
    byp_d     = byp_q;
    byp_sel_d = xfer.collision;
    if (xfer.collision) begin
      byp_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      byp_q     <= '0;
      byp_sel_q <= 1'b0;
    end else begin
      byp_q     <= byp_d;
      byp_sel_q <= byp_sel_d;
    end
  end

  assign data_o = byp_sel_q ? byp_q : ram_rd_data_i;
`else
  assign data_o = ram_rd_data_i;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ready_o        = ready_q;
  assign valid_o        = valid_q;
  assign count_o        = CntW'(occ);
  assign ram_wr_valid_o = xfer.push;
  assign ram_wr_addr_o  = wr_ptr[AddrW-1:0];
  assign ram_wr_data_o  = data_i;
  // Issued every cycle: the entry that will be the head next cycle.
  assign ram_rd_addr_o  = rd_ptr_next[AddrW-1:0];

endmodule

// File: tb/tb_fifo_ctrl_1r1w_sync.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl_1r1w_sync
//   Directed bench for fifo_ctrl_1r1w_sync (width_p=8, depth_p=4) with a
//   synchronous 1R1W RAM model and a queue-based reference of the FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl_1r1w_sync;

  localparam int W = 8;
  localparam int D = 4;
`ifdef FIFO_CTRL_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         valid_i = 1'b0;
  logic [W-1:0] data_i  = '0;
  logic         ready_i = 1'b0;
  logic         ready_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic [2:0]   count_o;
  logic         ram_wr_valid_o;
  logic [1:0]   ram_wr_addr_o;
  logic [W-1:0] ram_wr_data_o;
  logic [1:0]   ram_rd_addr_o;
  logic [W-1:0] ram_rd_data;

  fifo_ctrl_1r1w_sync #(
    .width_p        (W),
    .depth_p        (D)
  ) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .valid_o        (valid_o),
    .data_o         (data_o),
    .ready_i        (ready_i),
    .count_o        (count_o),
    .ram_wr_valid_o (ram_wr_valid_o),
    .ram_wr_addr_o  (ram_wr_addr_o),
    .ram_wr_data_o  (ram_wr_data_o),
    .ram_rd_addr_o  (ram_rd_addr_o),
    .ram_rd_data_i  (ram_rd_data)
  );

  // ---------------- RAM model: sync 1R1W, poisoned read-during-write ----------------
  logic [W-1:0] mem [D];
  initial forever begin
    @(posedge clk_i);
    if (ram_wr_valid_o && ram_wr_addr_o == ram_rd_addr_o) ram_rd_data <= 8'hEE;
    else ram_rd_data <= mem[ram_rd_addr_o];
    if (ram_wr_valid_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference FIFO: contents as a queue, plus the outputs the rules require.
  logic [W-1:0] exp_q[$];
  bit m_valid = 1'b0;
  bit m_ready = 1'b1;
  int wr_cnt  = 0;

  initial forever begin
    @(posedge clk_i or negedge reset_ni);
    if (!reset_ni) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_ready = 1'b1;
      wr_cnt  = 0;
    end else begin
      bit m_push, m_pop, m_coll;
      m_push = valid_i && m_ready;
      m_pop  = m_valid && ready_i;
      // A push landing in a FIFO that is empty once this cycle's pop is done
      m_coll = m_push && (exp_q.size() == (m_pop ? 1 : 0));
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back(data_i);
        wr_cnt++;
      end
      m_ready = (exp_q.size() != D);
      m_valid = (exp_q.size() != 0) && (Byp || !m_coll);
    end
  end

  // Every-cycle comparison against the reference.
  initial forever begin
    @(negedge clk_i);
    check("count_o", int'(count_o), exp_q.size());
    check("ready_o", int'(ready_o), int'(m_ready));
    check("valid_o", int'(valid_o), int'(m_valid));
    check("ram_wr_valid_o", int'(ram_wr_valid_o), int'(reset_ni && valid_i && m_ready));
    if (m_valid) check("data_o", int'(data_o), int'(exp_q[0]));
    if (reset_ni && valid_i && m_ready) begin
      check("ram_wr_addr_o", int'(ram_wr_addr_o), wr_cnt % D);
      check("ram_wr_data_o", int'(ram_wr_data_o), int'(data_i));
    end
  end

  // Record every beat handed to the consumer.
  logic [W-1:0] out_q[$];
  initial forever begin
    @(negedge clk_i);
    if (reset_ni && valid_o && ready_i) out_q.push_back(data_o);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < 20) begin
      drive(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("drain_budget", exp_q.size(), 0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [W-1:0] base, input int n);
    check({name, "_len"}, out_q.size(), n);
    for (int i = 0; i < n && i < out_q.size(); i++)
      check({name, "_data"}, int'(out_q[i]), int'(base) + i);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int max_cnt;
    int cyc;
    int idx;
    bit acc;
    logic [3:0] bp_pat;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", int'(valid_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_ready", int'(ready_o), 1);
    #2 reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single beat into an empty FIFO
    out_q.delete();
    drive(1'b1, 8'hA5, 1'b1);
    check("single_n1_valid", int'(valid_o), int'(Byp));
`ifdef FIFO_CTRL_BYPASS_EN
    check("single_n1_data", int'(data_o), 8'hA5);
    drive(1'b0, 8'h00, 1'b1);
    check("single_n2_valid", int'(valid_o), 0);
`else
    drive(1'b0, 8'h00, 1'b1);
    check("single_n2_valid", int'(valid_o), 1);
    check("single_n2_data", int'(data_o), 8'hA5);
`endif
    drain();
    check_out("single", 8'hA5, 1);

    // Fill to full with the consumer stalled
    out_q.delete();
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0);
    check("fill_count", int'(count_o), 4);
    check("fill_ready", int'(ready_o), 0);
    drive(1'b1, 8'h05, 1'b0);
    check("fill_5th_count", int'(count_o), 4);
    check("fill_5th_ready", int'(ready_o), 0);
    drive(1'b0, 8'h00, 1'b1);
    check("fill_pop_ready", int'(ready_o), 1);
    check("fill_pop_count", int'(count_o), 3);
    drain();
    check_out("fill", 8'h01, 4);

    // Streaming at full rate
    out_q.delete();
    max_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
    end
    check("stream_rate", out_q.size(), Byp ? 11 : 10);
    check("stream_max_count_le2", int'(max_cnt <= 2), 1);
    drain();
    check_out("stream", 8'h00, 12);

    // Streaming with consumer backpressure 1,0,0,1
    out_q.delete();
    bp_pat = 4'b1001;
    cyc = 0;
    idx = 0;
    while (idx < 12 && cyc < 200) begin
      acc = ready_o;
      drive(1'b1, 8'h40 + 8'(idx), bp_pat[cyc % 4]);
      if (acc) idx++;
      cyc++;
    end
    check("bp_budget", idx, 12);
    drain();
    check_out("bp", 8'h40, 12);

    // Collision: one entry stored, pop and push together
    out_q.delete();
    drive(1'b1, 8'h30, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("coll_pre_valid", int'(valid_o), 1);
    check("coll_pre_data", int'(data_o), 8'h30);
    check("coll_pre_count", int'(count_o), 1);
    drive(1'b1, 8'h31, 1'b1);
    check("coll_n1_valid", int'(valid_o), int'(Byp));
    check("coll_n1_count", int'(count_o), 1);
`ifdef FIFO_CTRL_BYPASS_EN
    check("coll_n1_data", int'(data_o), 8'h31);
`endif
    drive(1'b0, 8'h00, 1'b0);
    check("coll_n2_valid", int'(valid_o), 1);
    check("coll_n2_data", int'(data_o), 8'h31);
    drain();
    check_out("coll", 8'h30, 2);

    // Reset mid-stream
    drive(1'b1, 8'h50, 1'b0);
    drive(1'b1, 8'h51, 1'b0);
    check("midrst_pre_count", int'(count_o), 2);
    valid_i = 1'b1;
    data_i  = 8'h52;
    #2 reset_ni = 1'b0;
    #1;
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_count", int'(count_o), 0);
    check("midrst_ready", int'(ready_o), 1);
    check("midrst_wr", int'(ram_wr_valid_o), 0);
    @(posedge clk_i);
    #1;
    check("midrst_wr_hold", int'(ram_wr_valid_o), 0);
    #2 reset_ni = 1'b1;
    valid_i = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    check("postrst_valid", int'(valid_o), 0);
    check("postrst_count", int'(count_o), 0);
    out_q.delete();
    drive(1'b1, 8'h60, 1'b1);
    drain();
    check_out("postrst", 8'h60, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
